key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning the stable-input time in sys_clk cycles (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter LONG_CYCLES, default 50_000_000, meaning the held-press time for a long-press event (1 s at 50 MHz).
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port key, input, 2 bits: raw asynchronous push-buttons, active-low (0 = pressed).
REQ-006 The block SHALL have port key_level, output, 2 bits: debounced key state, active-low, a drop-in replacement for raw key.
REQ-007 The block SHALL have port key_press, output, 2 bits: one-cycle pulse per key on a debounced press.
REQ-008 The block SHALL have port key_release, output, 2 bits: one-cycle pulse per key on a debounced release.
REQ-009 The block SHALL have port key_long, output, 2 bits: one-cycle pulse per key when a press has been held LONG_CYCLES.

Function
REQ-010 Each key bit SHALL pass through a 2-flop synchronizer before any other logic; both channels SHALL be independent and identical.
REQ-011 Each channel SHALL implement a four-state FSM: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 IDLE -> PRESS_WAIT when the synchronized key is 0; the debounce counter SHALL clear on entry.
REQ-013 In PRESS_WAIT, a synchronized 1 SHALL return to IDLE and clear the counter (bounce rejected, no pulse).
REQ-014 In PRESS_WAIT, on the cycle the counter equals DEBOUNCE_CYCLES-1 with input still 0: -> PRESSED, key_press pulses 1 cycle, key_level bit goes 0, long counter clears.
REQ-015 In PRESSED, the long counter SHALL increment each cycle; at LONG_CYCLES-1, key_long SHALL pulse exactly once per press, and the counter SHALL saturate with no repeat.
REQ-016 PRESSED -> RELEASE_WAIT when the synchronized key is 1; the debounce counter SHALL clear.
REQ-017 In RELEASE_WAIT, a synchronized 0 SHALL return to PRESSED with the long counter preserved and no pulse.
REQ-018 In RELEASE_WAIT, at counter DEBOUNCE_CYCLES-1 with input still 1: -> IDLE, key_release pulses 1 cycle, key_level bit goes 1.
REQ-019 Latency SHALL be exactly 2+DEBOUNCE_CYCLES rising edges from the first edge sampling a stable raw level to the pulse and level update.
REQ-020 Counter widths SHALL be derived from the parameters via $clog2, unsigned, with no wrap-around during counting.
REQ-021 Simultaneous events on both keys SHALL produce simultaneous pulses on both bits; the channels SHALL never interact.
REQ-022 key_press, key_release and key_long SHALL never be asserted for more than one consecutive cycle; key_press and key_release SHALL never both be asserted on the same bit.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 While sys_rst=1 at a clock edge: both FSMs -> IDLE, all counters 0, synchronizer flops 1, key_level=2'b11, key_press=key_release=key_long=2'b00.
REQ-025 Reset asserted mid-press SHALL abort the press with no release pulse; after release of reset, a key still held low SHALL be re-debounced from IDLE.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the default DEBOUNCE_CYCLES and LONG_CYCLES constants, and the simulation override values 10 and 50.
REQ-027 One sub-module, key_debounce_ch, SHALL implement a single channel (synchronizer, FSM, counters); key_debounce SHALL instantiate it twice.

Verification (DEBOUNCE_CYCLES=10, LONG_CYCLES=50)
REQ-028 After reset, key=2'b11 held 100 cycles -> key_level=2'b11 and all pulses stay 0.
REQ-029 key[0] driven to 0 and held -> key_press=2'b01 for exactly one cycle, 12 edges later, and key_level=2'b10 from that cycle.
REQ-030 key[0] low in a 0,0,1,0... pattern, never 10 stable cycles -> no key_press pulse and key_level unchanged.
REQ-031 key[1] held low 80 cycles, then released -> key_long=2'b10 once, 50 cycles after key_press; key_release=2'b10 12 cycles after release.
REQ-032 Both keys fall on the same edge -> key_press=2'b11 on a single cycle; then sys_rst pulsed mid-press -> key_level=2'b11 with no key_release, and key_press re-fires 12 cycles after reset deassertion.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// rtl/key_debounce_pkg.sv - shared state encoding and timing constants for the key debouncer
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } kd_state_e;

    // 20 ms debounce and 1 s long-press at a 50 MHz sys_clk
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_LONG_CYCLES     = 50_000_000;

    // Short values that keep simulations quick
    localparam int SIM_DEBOUNCE_CYCLES = 10;
    localparam int SIM_LONG_CYCLES     = 50;

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: 2-flop synchronizer, debounce FSM, long-press timer
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    // Long counter must hold LONG_CYCLES itself so it can saturate past the pulse point
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LW = $clog2(LONG_CYCLES + 1);

    logic          sync1, sync2;
    kd_state_e     state, state_nx;
    logic [DW-1:0] dcnt;
    logic [LW-1:0] lcnt;
    logic          deb_done, long_hit;
    logic          press_d, release_d, long_d, level_d;

    assign deb_done = (dcnt == DW'(DEBOUNCE_CYCLES - 1));
    assign long_hit = (lcnt == LW'(LONG_CYCLES - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            state       <= IDLE;
            dcnt        <= '0;
            lcnt        <= '0;
            key_level   <= 1'b1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            sync1       <= key;
            sync2       <= sync1;
            state       <= state_nx;
            key_level   <= level_d;
            key_press   <= press_d;
            key_release <= release_d;
            key_long    <= long_d;

            // Staying in a wait state implies deb_done is false, so no wrap
            if (state_nx != state) begin
                dcnt <= '0;
            end else if (state == PRESS_WAIT || state == RELEASE_WAIT) begin
                dcnt <= dcnt + 1'b1;
            end

            // RELEASE_WAIT holds lcnt so a release bounce keeps the press timing
            if (press_d) begin
                lcnt <= '0;
            end else if (state == PRESSED && lcnt != LW'(LONG_CYCLES)) begin
                lcnt <= lcnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:         if (!sync2) state_nx = PRESS_WAIT;
            PRESS_WAIT:   if (sync2) state_nx = IDLE;
                          else if (deb_done) state_nx = PRESSED;
            PRESSED:      if (sync2) state_nx = RELEASE_WAIT;
            RELEASE_WAIT: if (!sync2) state_nx = PRESSED;
                          else if (deb_done) state_nx = IDLE;
            default:      state_nx = IDLE;
        endcase
    end

    always_comb begin
        press_d   = (state == PRESS_WAIT) && !sync2 && deb_done;
        release_d = (state == RELEASE_WAIT) && sync2 && deb_done;
        long_d    = (state == PRESSED) && long_hit;
        level_d   = key_level;
        if (press_d) begin
            level_d = 1'b0;
        end else if (release_d) begin
            level_d = 1'b1;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two independent debounced push-button channels
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] key,
    output logic [1:0] key_level,
    output logic [1:0] key_press,
    output logic [1:0] key_release,
    output logic [1:0] key_long
);

    key_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch0 (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key         (key[0]),
        .key_level   (key_level[0]),
        .key_press   (key_press[0]),
        .key_release (key_release[0]),
        .key_long    (key_long[0])
    );

    key_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch1 (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key         (key[1]),
        .key_level   (key_level[1]),
        .key_press   (key_press[1]),
        .key_release (key_release[1]),
        .key_long    (key_long[1])
    );

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - scoreboard bench for key_debounce against a run-length reference model
module tb_key_debounce;
    import key_debounce_pkg::*;

    localparam int D = SIM_DEBOUNCE_CYCLES;
    localparam int L = SIM_LONG_CYCLES;

    typedef struct packed {
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
        logic [1:0] lng;
    } exp_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [1:0] key = 2'b11;
    logic [1:0] key_level, key_press, key_release, key_long;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: a level flips once the synchronized input has
    // disagreed with it for D+1 consecutive FSM samples; raw key reaches
    // the FSM two edges after it is sampled.
    logic [1:0] m_s1 = 2'b11, m_s2 = 2'b11, m_lvl = 2'b11;
    int         m_run[2];
    int         m_pcnt[2];

    key_debounce #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key         (key),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step(input logic [1:0] k, input logic r);
        exp_t e;
        logic fin;
        @(negedge sys_clk);
        key     = k;
        sys_rst = r;
        e = '0;
        if (r) begin
            m_s1 = 2'b11;
            m_s2 = 2'b11;
            m_lvl = 2'b11;
            for (int c = 0; c < 2; c++) begin
                m_run[c]  = 0;
                m_pcnt[c] = 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                fin = m_s2[c];
                // Held-down time accrues only while no release is pending
                if (m_lvl[c] == 1'b0 && m_run[c] == 0 && m_pcnt[c] < L) begin
                    m_pcnt[c]++;
                    if (m_pcnt[c] == L) e.lng[c] = 1'b1;
                end
                if (fin != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D + 1) begin
                        m_lvl[c] = fin;
                        m_run[c] = 0;
                        if (fin == 1'b0) begin
                            e.prs[c]  = 1'b1;
                            m_pcnt[c] = 0;
                        end else begin
                            e.rel[c] = 1'b1;
                        end
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = k;
        end
        e.lvl = m_lvl;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc++;
                chk("key_level",   key_level,   e.lvl);
                chk("key_press",   key_press,   e.prs);
                chk("key_release", key_release, e.rel);
                chk("key_long",    key_long,    e.lng);
            end
        end
    end

    initial begin : driver
        logic [1:0] cur;
        int         hold[2];
        logic       r;
        for (int c = 0; c < 2; c++) begin
            m_run[c]  = 0;
            m_pcnt[c] = 0;
            hold[c]   = 0;
        end
        cur = 2'b11;

        repeat (3)  step(2'b11, 1'b1);
        repeat (100) step(2'b11, 1'b0);
        // single press on key[0]
        repeat (30) step(2'b10, 1'b0);
        repeat (20) step(2'b11, 1'b0);
        // bounce that never stays low for a full debounce window
        for (int i = 0; i < 12; i++) begin
            step(2'b10, 1'b0);
            step(2'b10, 1'b0);
            step(2'b11, 1'b0);
        end
        repeat (20) step(2'b11, 1'b0);
        // long press on key[1]
        repeat (80) step(2'b01, 1'b0);
        repeat (30) step(2'b11, 1'b0);
        // simultaneous press, reset mid-press, re-debounce while still held
        repeat (30) step(2'b00, 1'b0);
        repeat (2)  step(2'b00, 1'b1);
        repeat (30) step(2'b00, 1'b0);
        repeat (30) step(2'b11, 1'b0);
        // release-side bounce while held long
        repeat (20) step(2'b10, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(2'b11, 1'b0);
            step(2'b10, 1'b0);
        end
        repeat (40) step(2'b10, 1'b0);
        repeat (30) step(2'b11, 1'b0);

        // randomized holds around the debounce window, rare resets
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (hold[c] == 0) begin
                    cur[c]  = 1'($urandom_range(0, 1));
                    hold[c] = (($urandom_range(0, 3) == 0) ? $urandom_range(40, 70)
                                                           : $urandom_range(1, 14));
                end
                hold[c]--;
            end
            r = ($urandom_range(0, 499) == 0);
            step(cur, r);
        end
        repeat (30) step(2'b11, 1'b0);

        repeat (3) @(posedge sys_clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
